// File: rtl/ascon_permutation_if.sv
// Handshake and data bundle between the mode controller, the Ascon
// permutation core and the round-constant table.
interface ascon_permutation_if;
  logic         start_i;
  logic [3:0]   rounds_i;
  logic [319:0] state_i;
  logic [63:0]  const_i;
  logic [3:0]   round_idx_o;
  logic [319:0] state_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  // Core side: consumes requests and constants, produces results and index.
  modport slave (
    input  start_i, rounds_i, state_i, const_i,
    output round_idx_o, state_o, busy_o, done_o, err_o
  );

  // Controller/table side: the mirror image of the core.
  modport master (
    output start_i, rounds_i, state_i, const_i,
    input  round_idx_o, state_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation p^a: one full round (constant addition,
// S-box layer, linear layer) per clock on a 320-bit state register.
// The round constant arrives combinationally from an external table
// addressed by round_idx_o.
module ascon_permutation #(
  parameter int MAX_ROUNDS = 12
) (
  input logic              clk,
  input logic              rst_n,
  ascon_permutation_if.slave bus
);

  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [319:0] state_p0;
  logic [3:0]   idx_q;
  logic [3:0]   cnt_q;
  logic         err_q;
  logic         load;
  logic         reject;
  logic         legal;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // One Ascon round on the packed state x0..x4 (x0 in the top word).
  function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                               input logic [63:0]  c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2 = x2 ^ c;
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign legal = (bus.rounds_i != 4'd0) && (bus.rounds_i <= MAXR);

  // Next-state decode: starts are only looked at in IDLE.
  always_comb begin
    fsm_d  = fsm_q;
    load   = 1'b0;
    reject = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          if (legal) begin
            load  = 1'b1;
            fsm_d = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN:     if (cnt_q == 4'd1) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // Stage p0: state, round index and remaining-round counter; a reset
  // mid-run discards the partial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      state_p0 <= bus.state_i;
      idx_q    <= MAXR - bus.rounds_i;
      cnt_q    <= bus.rounds_i;
    end else if (fsm_q == RUN) begin
      state_p0 <= ascon_round(state_p0, bus.const_i);
      idx_q    <= idx_q + 4'd1;
      cnt_q    <= cnt_q - 4'd1;
    end else if (fsm_q == DONE) begin
      idx_q    <= '0;
    end
  end

  // Error flag: one cycle after an illegal round count is refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= reject;
  end

  assign bus.round_idx_o = idx_q;
  assign bus.state_o     = state_p0;
  assign bus.busy_o      = (fsm_q != IDLE);
  assign bus.done_o      = (fsm_q == DONE);
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Bench for ascon_permutation: a table of start requests checked against
// a bitwise S-box-table reference model, plus hand-written sequences for
// reset mid-run, the single-round closed form and a held start_i.
module tb_ascon_permutation;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  logic [319:0] last_state;

  ascon_permutation_if bus ();

  ascon_permutation #(.MAX_ROUNDS(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-constant table: ((15-i) << 4) | i.
  function automatic logic [63:0] rc(input int i);
    return 64'((((15 - i) & 15) << 4) | (i & 15));
  endfunction

  always_comb bus.const_i = rc(int'(bus.round_idx_o));

  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference p^a: words in an array, S-box applied column by column via table.
  function automatic logic [319:0] model(input logic [319:0] s, input int a);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    int r1 [5];
    int r2 [5];
    logic [319:0] res;
    r1 = '{19, 61, 1, 10, 7};
    r2 = '{28, 39, 6, 17, 41};
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = 12 - a; r < 12; r++) begin
      x[2] = x[2] ^ rc(r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox(col);
        for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
      end
      for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], r1[w]) ^ rotr(y[w], r2[w]);
    end
    for (int w = 0; w < 5; w++) res[319 - 64*w -: 64] = x[w];
    return res;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   rounds;
    logic [319:0] st;
    bit           exp_err;
    logic [319:0] exp_st;
  } vec_t;

  vec_t vt [12];

  // Drive one start request and follow it to completion (or rejection).
  task automatic run_vec(input vec_t v);
    int a;
    a = int'(v.rounds);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.rounds_i = v.rounds;
    bus.state_i  = v.st;
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
    bus.rounds_i = $urandom_range(0, 15);
    bus.state_i  = rnd320();
    if (v.exp_err) begin
      chk("err_pulse", 320'(bus.err_o), 320'(1));
      chk("err_busy", 320'(bus.busy_o), 320'(0));
      chk("err_state_held", bus.state_o, last_state);
      @(posedge clk); #1;
      chk("err_clear", 320'(bus.err_o), 320'(0));
    end else begin
      for (int i = 0; i < a; i++) begin
        chk("run_busy", 320'(bus.busy_o), 320'(1));
        chk("run_done_low", 320'(bus.done_o), 320'(0));
        chk("run_idx", 320'(bus.round_idx_o), 320'(12 - a + i));
        @(posedge clk); #1;
      end
      chk("done_high", 320'(bus.done_o), 320'(1));
      chk("done_state", bus.state_o, v.exp_st);
      @(posedge clk); #1;
      chk("idle_done_low", 320'(bus.done_o), 320'(0));
      chk("idle_busy_low", 320'(bus.busy_o), 320'(0));
      chk("idle_idx_zero", 320'(bus.round_idx_o), 320'(0));
      chk("idle_state_held", bus.state_o, v.exp_st);
      last_state = v.exp_st;
    end
  endtask

  function automatic vec_t mkvec(input logic [3:0] r, input logic [319:0] s);
    vec_t v;
    v.rounds  = r;
    v.st      = s;
    v.exp_err = (r == 4'd0) || (r > 4'd12);
    v.exp_st  = v.exp_err ? '0 : model(s, int'(r));
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [319:0] s;
    logic [63:0]  k, nk;
    nvec = 0;
    nerr = 0;
    last_state = '0;
    rst_n = 1'b0;
    bus.start_i  = 1'b0;
    bus.rounds_i = 4'd0;
    bus.state_i  = '0;

    vt[0]  = mkvec(4'd12, '0);
    vt[1]  = mkvec(4'd1,  '0);
    vt[2]  = mkvec(4'd8,  rnd320());
    vt[3]  = mkvec(4'd6,  rnd320());
    vt[4]  = mkvec(4'd0,  rnd320());
    vt[5]  = mkvec(4'd13, rnd320());
    vt[6]  = mkvec(4'd15, rnd320());
    for (int i = 7; i < 12; i++) vt[i] = mkvec(4'($urandom_range(1, 12)), rnd320());

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 320'(bus.busy_o), 320'(0));
    chk("rst_done", 320'(bus.done_o), 320'(0));
    chk("rst_err", 320'(bus.err_o), 320'(0));
    chk("rst_idx", 320'(bus.round_idx_o), 320'(0));
    chk("rst_state", bus.state_o, 320'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Single round on zero state: closed form with K = 0x4b
    run_vec(mkvec(4'd1, '0));
    k  = 64'h4b;
    nk = ~(k ^ rotr(k, 1) ^ rotr(k, 6));
    s  = {k ^ rotr(k, 19) ^ rotr(k, 28), k ^ rotr(k, 61) ^ rotr(k, 39), nk,
          k ^ rotr(k, 10) ^ rotr(k, 17), 64'd0};
    chk("p1_closed_form", bus.state_o, s);

    // Reset during round 5 of 12
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.rounds_i = 4'd12;
    bus.state_i  = rnd320();
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_idx", 320'(bus.round_idx_o), 320'(4));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 320'(bus.busy_o), 320'(0));
    chk("arst_state", bus.state_o, 320'(0));
    chk("arst_idx", 320'(bus.round_idx_o), 320'(0));
    chk("arst_done", 320'(bus.done_o), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_state = '0;
    run_vec(mkvec(4'd12, rnd320()));

    // start_i held high through RUN and DONE
    v = mkvec(4'd3, rnd320());
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.rounds_i = v.rounds;
    bus.state_i  = v.st;
    @(posedge clk); #1;
    chk("hold_busy", 320'(bus.busy_o), 320'(1));
    chk("hold_idx0", 320'(bus.round_idx_o), 320'(9));
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_idx", 320'(bus.round_idx_o), 320'(9 + i));
      chk("hold_no_done", 320'(bus.done_o), 320'(0));
    end
    @(posedge clk); #1;
    chk("hold_done", 320'(bus.done_o), 320'(1));
    chk("hold_state", bus.state_o, v.exp_st);
    @(posedge clk); #1;
    chk("hold_gap_busy", 320'(bus.busy_o), 320'(0));
    chk("hold_gap_done", 320'(bus.done_o), 320'(0));
    chk("hold_gap_err", 320'(bus.err_o), 320'(0));
    @(posedge clk); #1;
    chk("hold_rerun_busy", 320'(bus.busy_o), 320'(1));
    chk("hold_rerun_idx", 320'(bus.round_idx_o), 320'(9));
    bus.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rerun_no_done", 320'(bus.done_o), 320'(0));
    @(posedge clk); #1;
    chk("hold_rerun_done", 320'(bus.done_o), 320'(1));
    chk("hold_rerun_state", bus.state_o, v.exp_st);
    @(posedge clk); #1;
    chk("hold_end_busy", 320'(bus.busy_o), 320'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
